ok_wire_master: RTL

OK_WIRE_MASTER -- requirements
Module: ok_wire_master

---
 rtl/ok_wire_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ok_wire_master.sv
// ok_wire_master
//   Single-command host-side master for an ok1/ok2 style endpoint bus.
//   A command (WRITE, READ, UPDATE, CAPTURE) is accepted through a
//   valid/ready handshake and turned into a one-cycle strobe on ok1.
//   READs then wait up to TIMEOUT cycles for ok2[16] and report the result
//   as a one-cycle rsp_valid pulse; rsp_err flags a timeout.
//
// Ports
//   ti_clk     in   1   clock, rising edge
//   ti_rst_n   in   1   asynchronous active-low reset
//   cmd_valid  in   1   command offered
//   cmd_ready  out  1   command accepted when cmd_valid && cmd_ready on an edge
//   cmd_op     in   2   0 WRITE, 1 READ, 2 UPDATE, 3 CAPTURE
//   cmd_addr   in   8   endpoint address
//   cmd_data   in   16  write data
//   ok1        out  31  [15:0] data, [23:16] addr, [24] wr, [25] rd,
//                       [26] wire_in_update, [27] wire_out_capture
//   ok2        in   17  [15:0] data, [16] valid
//   rsp_valid  out  1   one-cycle read result pulse
//   rsp_data   out  16  read data, held until the next rsp_valid
//   rsp_err    out  1   1 = read timed out (rsp_data = 0)
//   busy       out  1   high whenever the FSM is not in IDLE
//
// All outputs come straight from registers that are updated together with
// the state register, so every output reflects the state being occupied.
module ok_wire_master #(
  parameter int TIMEOUT = 15
) (
  input  logic        ti_clk,
  input  logic        ti_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic [30:0] ok1,
  input  logic [16:0] ok2,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_UPDATE    = 3'd2,
    S_CAPTURE   = 3'd3,
    S_READ_REQ  = 3'd4,
    S_READ_WAIT = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      r_state;
  logic [3:0]  r_strb;      // {capture, update, read, write}
  logic [7:0]  r_addr;
  logic [15:0] r_data;
  logic [7:0]  r_cnt;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_busy;
  logic [7:0]  w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 8'd1;

  assign ok1       = {3'b000, r_strb, r_addr, r_data};
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

  // Command FSM with all outputs registered alongside the state.
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      r_state     <= S_IDLE;
      r_strb      <= 4'b0000;
      r_addr      <= 8'h00;
      r_data      <= 16'h0000;
      r_cnt       <= 8'h00;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Strobes and the response pulse last one cycle unless re-armed below.
      r_strb      <= 4'b0000;
      r_addr      <= 8'h00;
      r_data      <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready is still low on the first edge after reset release.
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (cmd_op)
              2'd0: begin
                r_state <= S_WRITE;
                r_strb  <= 4'b0001;
                r_addr  <= cmd_addr;
                r_data  <= cmd_data;
              end
              2'd1: begin
                r_state <= S_READ_REQ;
                r_strb  <= 4'b0010;
                r_addr  <= cmd_addr;
              end
              2'd2: begin
                r_state <= S_UPDATE;
                r_strb  <= 4'b0100;
              end
              default: begin
                r_state <= S_CAPTURE;
                r_strb  <= 4'b1000;
              end
            endcase
          end else begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_WRITE, S_UPDATE, S_CAPTURE, S_RESP: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        S_READ_REQ: begin
          // ok2 is deliberately not looked at here.
          r_state <= S_READ_WAIT;
          r_cnt   <= 8'h00;
        end
        S_READ_WAIT: begin
          if (ok2[16]) begin
            // Valid wins even on the edge the counter would time out.
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= ok2[15:0];
            r_rsp_err   <= 1'b0;
          end else if (w_cnt_nxt == TIMEOUT_C) begin
            r_state     <= S_RESP;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 16'h0000;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
